// File: rtl/fifo_pkt_pkg.sv
// fifo_pkt_pkg: shared states, sync bytes and error codes for the command packet receiver.
package fifo_pkt_pkg;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_CMD,
      S_CMDN,
      S_LENL,
      S_LENH,
      S_PL
   } state_t;

   localparam logic [7:0] PKT_SYNC0 = 8'h2B;
   localparam logic [7:0] PKT_SYNC1 = 8'hD4;

   localparam logic [1:0] ERR_TOUT = 2'd0;
   localparam logic [1:0] ERR_HDR  = 2'd1;
   localparam logic [1:0] ERR_CMD  = 2'd2;
   localparam logic [1:0] ERR_LEN  = 2'd3;

endpackage

// File: rtl/fifo_pkt_rx.sv
// fifo_pkt_rx: pops bytes from the MCU FIFO head, parses 2B D4 cmd ~cmd len_lo len_hi headers
// and streams the payload; registers move on the falling clock edge like the rest of the base logic.
module fifo_pkt_rx
   import fifo_pkt_pkg::*;
#(
   parameter int MAX_LEN = 2048,
   parameter int TIMEOUT = 50000,
   parameter int RD_GAP  = 3
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_dato,
   output logic        fifo_rd,
   input  logic        pl_ready,
   output logic        pl_valid,
   output logic [7:0]  pl_data,
   output logic        pl_last,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic [15:0] cmd_len,
   output logic        busy,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  err_cnt,
   output logic [15:0] pkt_cnt
);

   localparam int GW = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t         state_q, state_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [TW-1:0]  tout_q, tout_d;
   logic [15:0]    rem_q, rem_d;
   logic [7:0]     cmd_q, cmd_d;
   logic [7:0]     lo_q, lo_d;
   logic           fifo_rd_q, fifo_rd_d;
   logic           pl_valid_q, pl_valid_d;
   logic [7:0]     pl_data_q, pl_data_d;
   logic           pl_last_q, pl_last_d;
   logic           cmd_valid_q, cmd_valid_d;
   logic [7:0]     cmd_code_q, cmd_code_d;
   logic [15:0]    cmd_len_q, cmd_len_d;
   logic           err_q, err_d;
   logic [1:0]     err_code_q, err_code_d;
   logic [7:0]     err_cnt_q, err_cnt_d;
   logic [15:0]    pkt_cnt_q, pkt_cnt_d;
   logic           pop, tout_hit;
   logic [15:0]    len;

   assign busy = (state_q != S_HDR0);

   always_comb begin
      len         = {fifo_dato, lo_q};
      pop         = !fifo_empty && (gap_q == '0) && (state_q != S_PL || pl_ready);
      tout_hit    = busy && fifo_empty && (tout_q == TW'(TIMEOUT - 1));
      state_d     = state_q;
      gap_d       = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
      tout_d      = (state_q == S_HDR0) ? '0 : (busy && fifo_empty) ? tout_q + TW'(1) : tout_q;
      rem_d       = rem_q;
      cmd_d       = cmd_q;
      lo_d        = lo_q;
      fifo_rd_d   = pop;
      pl_valid_d  = 1'b0;
      pl_data_d   = pl_data_q;
      pl_last_d   = 1'b0;
      cmd_valid_d = 1'b0;
      cmd_code_d  = cmd_code_q;
      cmd_len_d   = cmd_len_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      if (pop) begin
         gap_d  = GW'(RD_GAP);
         tout_d = '0;
         case (state_q)
            S_HDR0: state_d = (fifo_dato == PKT_SYNC0) ? S_HDR1 : S_HDR0;
            S_HDR1: begin
               // a repeated first sync byte keeps hunting for the second one
               if (fifo_dato == PKT_SYNC1) state_d = S_CMD;
               else if (fifo_dato != PKT_SYNC0) begin
                  state_d    = S_HDR0;
                  err_d      = 1'b1;
                  err_code_d = ERR_HDR;
               end
            end
            S_CMD: begin
               cmd_d   = fifo_dato;
               state_d = S_CMDN;
            end
            S_CMDN: begin
               state_d    = (fifo_dato == ~cmd_q) ? S_LENL : S_HDR0;
               err_d      = (fifo_dato != ~cmd_q);
               err_code_d = err_d ? ERR_CMD : err_code_q;
            end
            S_LENL: begin
               lo_d    = fifo_dato;
               state_d = S_LENH;
            end
            S_LENH: begin
               if (len > 16'(MAX_LEN)) begin
                  state_d    = S_HDR0;
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_code_d  = cmd_q;
                  cmd_len_d   = len;
                  rem_d       = len;
                  state_d     = (len == 16'd0) ? S_HDR0 : S_PL;
               end
            end
            S_PL: begin
               pl_valid_d = 1'b1;
               pl_data_d  = fifo_dato;
               rem_d      = rem_q - 16'd1;
               pl_last_d  = (rem_q == 16'd1);
               state_d    = pl_last_d ? S_HDR0 : S_PL;
            end
            default: state_d = S_HDR0;
         endcase
      end else if (tout_hit) begin
         state_d    = S_HDR0;
         tout_d     = '0;
         err_d      = 1'b1;
         err_code_d = ERR_TOUT;
      end
      err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
      pkt_cnt_d = cmd_valid_d ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
   end

   always_ff @(negedge clk) begin
      if (sys_rst) begin
         state_q     <= S_HDR0;
         gap_q       <= '0;
         tout_q      <= '0;
         rem_q       <= '0;
         cmd_q       <= '0;
         lo_q        <= '0;
         fifo_rd_q   <= 1'b0;
         pl_valid_q  <= 1'b0;
         pl_data_q   <= '0;
         pl_last_q   <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= '0;
         cmd_len_q   <= '0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         err_cnt_q   <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         tout_q      <= tout_d;
         rem_q       <= rem_d;
         cmd_q       <= cmd_d;
         lo_q        <= lo_d;
         fifo_rd_q   <= fifo_rd_d;
         pl_valid_q  <= pl_valid_d;
         pl_data_q   <= pl_data_d;
         pl_last_q   <= pl_last_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         cmd_len_q   <= cmd_len_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         err_cnt_q   <= err_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign fifo_rd   = fifo_rd_q;
   assign pl_valid  = pl_valid_q;
   assign pl_data   = pl_data_q;
   assign pl_last   = pl_last_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_len   = cmd_len_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign err_cnt   = err_cnt_q;
   assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: doc/fifo_pkt_rx.md
# fifo_pkt_rx

Command packet receiver sitting directly downstream of the MCU-to-Moto byte FIFO (fifo_a in the base I/O block, exposed as a byte FIFO head interface). Pops bytes, hunts for the sync header, validates command and length fields, then streams the payload to a mapper-side consumer. It also reports framing errors and a 1 ms inactivity timeout. This lets mapper logic take MCU commands without CPU polling of the FIFO data register.

## Interface
Parameters:
- MAX_LEN, 2048: largest accepted payload length in bytes; larger lengths are rejected.
- TIMEOUT, 50000: idle clk cycles allowed between bytes inside a packet (1 ms at 50 MHz).
- RD_GAP, 3: clk cycles after a pop before fifo_empty/fifo_dato are valid again.

Ports:
- clk  in  1  system clock; all registers update on the falling edge, as in the rest of the base logic.
- sys_rst  in  1  reset; synchronous, active-high.
- fifo_empty  in  1  FIFO holds no bytes.
- fifo_dato  in  8  FIFO head byte; valid when !fifo_empty and the gap has expired.
- fifo_rd  out  1  one-cycle pop strobe.
- pl_ready  in  1  consumer can take a payload byte.
- pl_valid  out  1  one-cycle payload byte pulse.
- pl_data  out  8  payload byte.
- pl_last  out  1  marks the final payload byte, coincident with pl_valid.
- cmd_valid  out  1  one-cycle pulse when the header is accepted.
- cmd_code  out  8  command byte; held until the next cmd_valid.
- cmd_len  out  16  payload length; held until the next cmd_valid.
- busy  out  1  high in any state other than S_HDR0.
- err  out  1  one-cycle error pulse.
- err_code  out  2  1 = header, 2 = command check, 3 = length, 0 = timeout; held until the next err.
- err_cnt  out  8  saturating error count.
- pkt_cnt  out  16  count of accepted headers; wraps.

## Operation
- Packet format: 0x2B, 0xD4, cmd, ~cmd, len_lo, len_hi, then len payload bytes.
- States: S_HDR0, S_HDR1, S_CMD, S_CMDN, S_LENL, S_LENH, S_PL.
- A byte is consumed by pop = !fifo_empty & gap==0 & (state!=S_PL | pl_ready).
- On pop: fifo_rd=1, fifo_dato is sampled on that edge, and gap is loaded with RD_GAP and counts down to 0.
- S_HDR0: 0x2B goes to S_HDR1. Any other byte is discarded silently, with no error.
- S_HDR1: 0xD4 goes to S_CMD. A repeated 0x2B stays in S_HDR1. Any other byte raises err, code 1, and returns to S_HDR0.
- S_CMD: latches the byte and goes to S_CMDN.
- S_CMDN: the byte must equal ~cmd, which goes to S_LENL. Otherwise err, code 2, and return to S_HDR0.
- S_LENL goes to S_LENH.
- S_LENH: assembles len = {hi, lo}.
  - len > MAX_LEN: err, code 3, return to S_HDR0. No cmd_valid, pkt_cnt unchanged.
  - len == 0: cmd_valid and return to S_HDR0.
  - Otherwise: cmd_valid, load the remaining-byte count, go to S_PL.
- S_PL: each pop emits pl_valid/pl_data the next cycle. The pop that takes the count to 0 also produces pl_last and returns to S_HDR0.
- Timeout counter: cleared on every pop and in S_HDR0. It increments only while busy & fifo_empty; stalls from pl_ready=0 do not count.
  - On reaching TIMEOUT-1: err with code 0, return to S_HDR0, and discard the partial packet. pl_last is not emitted.
- err_cnt saturates at 0xFF. pkt_cnt increments on each cmd_valid and wraps 0xFFFF→0.
- Simultaneous timeout and pop are impossible, since timeout requires fifo_empty. A sys_rst in the same cycle as a pop wins: the byte is lost.

## Timing
- Reset values:
  - State S_HDR0; gap, timeout and remaining counters 0.
  - fifo_rd, pl_valid, pl_last, cmd_valid, err, busy all 0.
  - pl_data, cmd_code, cmd_len, err_code, err_cnt, pkt_cnt all 0.
- Pops are at least RD_GAP+1 cycles apart, so one byte takes at least 4 cycles at the default gap.
- Pop on edge N, last byte of a stage:
  - cmd_valid appears at N+1.
  - pl_valid appears at N+1.
  - err appears at N+1.
- pl_ready is sampled only at the pop decision. The consumer must accept every pl_valid pulse; there is no hold.
- busy rises the cycle after the 0x2B pop and falls the cycle after the final pop, error or timeout.

## Structure
- Package fifo_pkt_pkg holds:
  - the state enum;
  - constants PKT_SYNC0=8'h2B and PKT_SYNC1=8'hD4;
  - err_code constants ERR_TOUT, ERR_HDR, ERR_CMD, ERR_LEN.
- The block is a single module with no sub-modules. The gap, timeout and remaining counters are inline.

## Test plan
- Send 2B D4 05 FA 03 00 11 22 33 with pl_ready=1: cmd_valid with cmd_code=05, cmd_len=3; pl_data 11, 22, 33 with pl_last on 33; pkt_cnt=1; no err.
- Send 2B D4 05 FB 00 00: err with err_code=2, err_cnt=1, no cmd_valid. Follow with a valid zero-length packet (cmd 07): cmd_valid with cmd_len=0 and no pl_valid.
- Send AA 2B 2B D4 01 FE 01 00 99: AA dropped silently and repeated sync tolerated; one cmd_valid (cmd 01) and pl_data=99 with pl_last.
- Send a header with len=0x0801: err with err_code=3, busy drops, and subsequent payload bytes are ignored until the next 2B D4.
- Send the header plus 1 of 4 payload bytes, then leave the FIFO empty for 50000 cycles: err with err_code=0 exactly at the limit, back in S_HDR0, no pl_last. Also hold pl_ready=0 for 60000 cycles with data present: no timeout.
- Assert sys_rst for 1 cycle mid-payload: all outputs at reset values next cycle, and the next valid packet is accepted normally.
